// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg: shared types and sizes for the four-way round-robin arbiter.
package mux4_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int DATA_W  = 16;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/mux4.sv
// mux4: 4:1 data multiplexer steered by the arbiter grant index.
module mux4 #(
  parameter int W = 16
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);
  always_comb y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin picker; first set request scanning ptr, ptr+1, ... mod 4.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   pick,
  output logic               any
);
  // Walk from the farthest offset back to ptr so the nearest request wins.
  always_comb begin
    pick = ptr;
    any  = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[ptr + SEL_W'(k)]) pick = ptr + SEL_W'(k);
  end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: packet-granular round-robin arbiter over four valid/ready sources.
// Optional ARB_BURST_LIMIT_EN releases a grant after MAX_BURST beats even without last.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [NUM_REQ-1:0]  req_last,
  input  logic [DATA_W-1:0]   req_data0,
  input  logic [DATA_W-1:0]   req_data1,
  input  logic [DATA_W-1:0]   req_data2,
  input  logic [DATA_W-1:0]   req_data3,
  output logic [NUM_REQ-1:0]  req_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic [SEL_W-1:0]    sel,
  output logic                busy
);
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("MAX_BURST must be in 1..255");
  end
  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic [SEL_W-1:0] w_pick;
  logic             w_any;
  logic             w_xfer;
  logic             w_done;
  rr_pick4 u_pick (
    .req  (req_valid),
    .ptr  (r_ptr),
    .pick (w_pick),
    .any  (w_any)
  );
  mux4 #(.W(DATA_W)) u_mux (
    .sel (r_sel),
    .d0  (req_data0),
    .d1  (req_data1),
    .d2  (req_data2),
    .d3  (req_data3),
    .y   (out_data)
  );
  assign w_xfer = out_valid && out_ready;
`ifdef ARB_BURST_LIMIT_EN
  logic [7:0] r_beat_cnt, w_cnt_nxt;
  assign w_done = w_xfer && (out_last || (r_beat_cnt + 8'd1 == 8'(MAX_BURST)));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_beat_cnt <= '0;
    else r_beat_cnt <= w_cnt_nxt;
  always_comb begin
    w_cnt_nxt = r_beat_cnt;
    if (r_state == IDLE) w_cnt_nxt = '0;
    else if (w_xfer && !w_done) w_cnt_nxt = r_beat_cnt + 8'd1;
  end
`else
  assign w_done = w_xfer && out_last;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  // sel only moves on IDLE->GRANT; completing a grant hands priority to sel+1.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    if (r_state == IDLE && w_any) begin
      w_state_nxt = GRANT;
      w_sel_nxt   = w_pick;
    end else if (r_state == GRANT && w_done) begin
      w_state_nxt = IDLE;
      w_ptr_nxt   = r_sel + 1'b1;
    end
  end
  always_comb begin
    busy      = r_state == GRANT;
    out_valid = busy && req_valid[r_sel];
    out_last  = busy && req_last[r_sel];
    req_ready = '0;
    req_ready[r_sel] = busy && out_ready;
    sel       = r_sel;
  end
endmodule
